seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, signed or unsigned, fixed N+1 edge latency.
// The partial remainder trial is N+1 bits wide so its borrow bit is exact for all magnitudes.
module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         signedFlag,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         divByZero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   dsr_q, dsr_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rmdr_q, rmdr_d;
    logic           divz_q, divz_d;

    logic           load;
    logic           a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     r_shift, diff;
    logic           ge;

    // An N-bit unsigned magnitude already holds 2^(N-1), the most-negative case.
    always_comb begin
        a_neg = signedFlag & dividend[N-1];
        b_neg = signedFlag & divisor[N-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divisor : divisor;
        load  = start && (state_q == IDLE || state_q == DONE);
    end

    always_comb begin
        r_shift = {rem_q, quo_q[N-1]};
        diff    = r_shift - {1'b0, dsr_q};
        ge      = ~diff[N];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        divz_d  = divz_q;
        busy_d  = (state_q == DIVIDE) || (state_q == FIXUP);

        case (state_q)
            DIVIDE: begin
                rem_d = ge ? diff[N-1:0] : r_shift[N-1:0];
                quo_d = {quo_q[N-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quot_d  = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
                rmdr_d  = dz_q ? dvd_q : (rneg_q ? -rem_q : rem_q);
                divz_d  = dz_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = DIVIDE;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dsr_d   = b_mag;
            dvd_d   = dividend;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (divisor == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            divz_q  <= divz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rmdr_q;
    assign divByZero = divz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus directed literal cases.
module tb_seq_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signedFlag = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy, done, divByZero;
    logic [N-1:0] quotient, remainder;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signedFlag(signedFlag),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (divByZero)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r, output logic dz);
        longint sa, sb, lq, lr;
        longint unsigned ua, ub;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q = lq[N-1:0]; r = lr[N-1:0]; dz = 1'b0;
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            q = N'(ua / ub); r = N'(ua % ub); dz = 1'b0;
        end
    endfunction

    // Model: k counts edges since acceptance (-1 when idle).
    int           k = -1;
    bit           m_s;
    logic [N-1:0] m_a, m_b;
    logic [N-1:0] exp_q = '0, exp_r = '0;
    logic         exp_dz = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            k = -1; exp_q = '0; exp_r = '0; exp_dz = 1'b0;
        end else if ((k == -1 || k == N + 1) && start) begin
            m_s = signedFlag; m_a = dividend; m_b = divisor; k = 0;
        end else if (k == N + 1) begin
            k = -1;
        end else if (k >= 0) begin
            k++;
            if (k == N + 1) ref_div(m_s, m_a, m_b, exp_q, exp_r, exp_dz);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, N'(k >= 1));
            chk("done", done, N'(k == N + 1));
            chk("quotient", quotient, exp_q);
            chk("remainder", remainder, exp_r);
            chk("divByZero", divByZero, N'(exp_dz));
        end
    end

    function automatic logic [N-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return N'(1);
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return N'($urandom_range(0, 15));
            default: return N'($urandom);
        endcase
    endfunction

    task automatic run_op(input bit s, input logic [N-1:0] a, input logic [N-1:0] b, input bit noisy);
        int lat;
        @(negedge clk);
        start = 1'b1; signedFlag = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
            if (noisy) begin
                start = (lat >= 4 && lat <= 19);
                dividend = N'($urandom); divisor = N'($urandom); signedFlag = 1'($urandom);
            end
        end
        start = 1'b0;
        chk("latency", N'(lat), N'(N + 1));
    endtask

    task automatic directed(input string name, input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz, input bit noisy);
        run_op(s, a, b, noisy);
        chk({name, " q"}, quotient, eq);
        chk({name, " r"}, remainder, er);
        chk({name, " dz"}, divByZero, N'(edz));
    endtask

    task automatic count_dones(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk(name, N'(seen), '0);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst busy", busy, '0);
        chk("rst done", done, '0);
        chk("rst q", quotient, '0);
        chk("rst r", remainder, '0);
        chk("rst dz", divByZero, '0);
        rst_n = 1'b1;

        directed("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        directed("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        directed("u-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
        directed("u/0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
        directed("s/0", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
        directed("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        directed("umax/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        directed("noisy", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);

        // Back-to-back with start held high; new operands presented in the done cycle.
        @(negedge clk);
        start = 1'b1; signedFlag = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        chk("b2b lat1", N'(lat), N'(N + 1));
        chk("b2b q1", quotient, 32'd333);
        chk("b2b r1", remainder, 32'd1);
        signedFlag = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
        chk("b2b lat2", N'(lat), N'(N + 1));
        chk("b2b q2", quotient, 32'hFFFF_FFF2);
        chk("b2b r2", remainder, 32'hFFFF_FFFE);

        // Abort mid-divide with reset at E10.
        @(negedge clk);
        start = 1'b1; signedFlag = 1'b0; dividend = 32'd500; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", busy, '0);
        chk("abort q", quotient, '0);
        chk("abort r", remainder, '0);
        count_dones("abort no done", 40);
        directed("post-abort", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Reset and start on the same edge: start must be dropped.
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        count_dones("rst-vs-start", 40);

        for (int i = 0; i < 1500; i++) begin
            run_op(1'($urandom), rand_op(), rand_op(), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
